// File: rtl/frame_sequencer.sv
// frame_sequencer: sequences one frame into the row buffer / window datapath.
// Latches the frame configuration, pulses frame start, gates the pixel stream,
// flags pixels that complete a strided window, then waits out the buffer flush.
//
// Handshake: a pixel transfers in a cycle where s_vld & s_rdy are both high.
// s_vld must hold s_data stable until it transfers; s_rdy is high only in
// STREAM and is forced low in a cycle where abort is high. The transfer is
// forwarded combinationally to the row buffer (buf_din_vld / buf_din).
module frame_sequencer #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int CH_NUM      = 3,
  parameter int WIN_SIZE    = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_vld,
  output logic                          cfg_rdy,
  input  logic [$clog2(FRAME_H_MAX):0]  cfg_h,
  input  logic [$clog2(FRAME_W_MAX):0]  cfg_w,
  input  logic [1:0]                    cfg_stride,
  output logic                          cfg_err,
  input  logic                          abort,
  input  logic                          s_vld,
  output logic                          s_rdy,
  input  logic [CH_NUM*DIN_WIDTH-1:0]   s_data,
  output logic                          buf_frame_start,
  output logic                          buf_din_vld,
  output logic [CH_NUM*DIN_WIDTH-1:0]   buf_din,
  output logic                          win_vld,
  output logic                          frame_done,
  output logic                          frame_aborted,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int HW = $clog2(FRAME_H_MAX) + 1;
  localparam int WW = $clog2(FRAME_W_MAX) + 1;
  localparam int DW = $clog2((WIN_SIZE - 1) * FRAME_W_MAX) + 1;

  localparam logic [HW-1:0] H_MAX  = HW'(FRAME_H_MAX);
  localparam logic [WW-1:0] W_MAX  = WW'(FRAME_W_MAX);
  localparam logic [HW-1:0] H_MIN  = HW'(WIN_SIZE);
  localparam logic [WW-1:0] W_MIN  = WW'(WIN_SIZE);
  // First row/column index at which a full window exists.
  localparam logic [HW-1:0] ROW_W0 = HW'(WIN_SIZE - 1);
  localparam logic [WW-1:0] COL_W0 = WW'(WIN_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d, row_q, row_d;
  logic [WW-1:0]   w_q, w_d, col_q, col_d;
  logic [1:0]      stride_q, stride_d, row_ph_q, row_ph_d, col_ph_q, col_ph_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            cfg_err_q, cfg_err_d, aborted_q, aborted_d;
  logic            accept, cfg_bad;
  logic [DW-1:0]   drain_len;

  // Flush length of the row buffer: WIN_SIZE-1 full rows.
  assign drain_len = DW'(WIN_SIZE - 1) * DW'(w_q);

  assign cfg_bad = (cfg_h < H_MIN) || (cfg_w < W_MIN) || (cfg_h > H_MAX) ||
                   (cfg_w > W_MAX) || !((cfg_stride == 2'd1) || (cfg_stride == 2'd2));

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d         = state_q;
    h_d             = h_q;
    w_d             = w_q;
    stride_d        = stride_q;
    row_d           = row_q;
    col_d           = col_q;
    row_ph_d        = row_ph_q;
    col_ph_d        = col_ph_q;
    drain_d         = drain_q;
    cfg_err_d       = 1'b0;
    aborted_d       = 1'b0;
    cfg_rdy         = 1'b0;
    s_rdy           = 1'b0;
    accept          = 1'b0;
    buf_frame_start = 1'b0;
    frame_done      = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_rdy = 1'b1;
        if (cfg_vld) begin
          h_d      = cfg_h;
          w_d      = cfg_w;
          stride_d = cfg_stride;
          if (cfg_bad) cfg_err_d = 1'b1;
          else         state_d   = START;
        end
      end
      START: begin
        buf_frame_start = 1'b1;
        row_d    = '0;
        col_d    = '0;
        row_ph_d = '0;
        col_ph_d = '0;
        drain_d  = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        s_rdy  = !abort;
        accept = s_vld && !abort;
        if (accept) begin
          if (col_q == w_q - WW'(1)) begin
            col_d    = '0;
            col_ph_d = '0;
            row_d    = row_q + HW'(1);
            // Phase restarts at the first window row, then cycles modulo stride.
            if (row_q + HW'(1) == ROW_W0)          row_ph_d = '0;
            else if (row_ph_q + 2'd1 == stride_q)  row_ph_d = '0;
            else                                   row_ph_d = row_ph_q + 2'd1;
            if (row_q == h_q - HW'(1)) state_d = DRAIN;
          end else begin
            col_d = col_q + WW'(1);
            if (col_q + WW'(1) == COL_W0)          col_ph_d = '0;
            else if (col_ph_q + 2'd1 == stride_q)  col_ph_d = '0;
            else                                   col_ph_d = col_ph_q + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == drain_len - DW'(1)) state_d = DONE;
        else                               drain_d = drain_q + DW'(1);
      end
      DONE: begin
        frame_done = !abort;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end
  end

  assign buf_din_vld   = accept;
  assign buf_din       = s_data;
  assign win_vld       = accept && (row_q >= ROW_W0) && (col_q >= COL_W0) &&
                         (row_ph_q == 2'd0) && (col_ph_q == 2'd0);
  assign cfg_err       = cfg_err_q;
  assign frame_aborted = aborted_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

  // State, configuration and position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      h_q       <= '0;
      w_q       <= '0;
      stride_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_ph_q  <= '0;
      col_ph_q  <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      w_q       <= w_d;
      stride_q  <= stride_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_ph_q  <= row_ph_d;
      col_ph_q  <= col_ph_d;
      drain_q   <= drain_d;
      cfg_err_q <= cfg_err_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: normal frames, strides, stalls,
// rejected configurations, abort and mid-frame reset.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_vld = 1'b0;
  logic        cfg_rdy;
  logic [8:0]  cfg_h = '0;
  logic [8:0]  cfg_w = '0;
  logic [1:0]  cfg_stride = '0;
  logic        cfg_err;
  logic        abort = 1'b0;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic [23:0] s_data = '0;
  logic        buf_frame_start;
  logic        buf_din_vld;
  logic [23:0] buf_din;
  logic        win_vld;
  logic        frame_done;
  logic        frame_aborted;
  logic        busy;
  logic [2:0]  dbg_state;

  frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_stride(cfg_stride), .cfg_err(cfg_err),
    .abort(abort), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
    .buf_frame_start(buf_frame_start), .buf_din_vld(buf_din_vld), .buf_din(buf_din),
    .win_vld(win_vld), .frame_done(frame_done), .frame_aborted(frame_aborted),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int cur_w = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b ^ 8'h5a, b, b + 8'h3c};
  endfunction

  // Monitor: counts events on the falling edge, away from the active edge.
  int cyc = 0;
  int n_start = 0, n_acc = 0, fr_acc = 0, n_done = 0, n_abort = 0, n_err = 0, n_busy = 0;
  int n_win = 0, start_cyc = 0, first_rdy_cyc = -1, last_acc_cyc = 0, done_cyc = 0;
  int din_bad = 0, vld_bad = 0;
  int win_log[0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buf_frame_start) begin
      n_start++;
      start_cyc = cyc;
      fr_acc = 0;
      first_rdy_cyc = -1;
    end
    if (s_rdy && (first_rdy_cyc < 0)) first_rdy_cyc = cyc;
    if (buf_din_vld !== (s_vld && s_rdy)) vld_bad++;
    if (win_vld && !buf_din_vld) vld_bad++;
    if (buf_din_vld) begin
      if (buf_din !== pix(fr_acc)) din_bad++;
      if (win_vld) begin
        if (n_win < 1024) win_log[n_win] = (fr_acc / cur_w) * 256 + (fr_acc % cur_w);
        n_win++;
      end
      fr_acc++;
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (frame_aborted) n_abort++;
    if (cfg_err) n_err++;
    if (busy) n_busy++;
  end

  // Driver tasks.
  task automatic do_cfg(input int h, input int w, input int s, input bit ab);
    @(posedge clk); #1;
    cfg_vld    = 1'b1;
    cfg_h      = 9'(h);
    cfg_w      = 9'(w);
    cfg_stride = 2'(s);
    abort      = ab;
    cur_w      = w;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic stream(input int total, input bit toggle, input int abort_k);
    int k = 0;
    int t = 0;
    while (k < total) begin
      if (t >= 4000) begin
        check("stream_budget", k, total);
        break;
      end
      s_vld  = toggle ? ((t % 2) == 0) : 1'b1;
      s_data = pix(k);
      if ((k == abort_k) && s_vld) abort = 1'b1;
      @(negedge clk);
      if (abort) begin
        check("abort_blocks_rdy", s_rdy, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        break;
      end
      if (s_vld && s_rdy) k++;
      @(posedge clk); #1;
      t++;
    end
    s_vld = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int limit);
    int n = 0;
    while ((n_done == base_done) && (n < limit)) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_frame(input string nm, input int h, input int w, input int s,
                           input bit toggle, input bit ab_in_cfg);
    int b_start = n_start, b_acc = n_acc, b_done = n_done, b_win = n_win;
    int b_ab = n_abort, b_bad = din_bad + vld_bad;
    check({nm, "_cfg_rdy_idle"}, cfg_rdy, 1);
    do_cfg(h, w, s, ab_in_cfg);
    stream(h * w, toggle, -1);
    check({nm, "_rdy_drop"}, {busy, s_rdy}, 2'b10);
    wait_done(b_done, 3000);
    check({nm, "_cfg_rdy_after"}, cfg_rdy, 1);
    check({nm, "_starts"}, n_start - b_start, 1);
    check({nm, "_start_to_rdy"}, first_rdy_cyc - start_cyc, 1);
    check({nm, "_accepted"}, n_acc - b_acc, h * w);
    check({nm, "_dones"}, n_done - b_done, 1);
    check({nm, "_drain_len"}, done_cyc - last_acc_cyc - 1, 2 * w);
    check({nm, "_win_count"}, n_win - b_win, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_win + i < n_win) check({nm, "_win_pos"}, win_log[b_win + i], exp_q[i]);
    check({nm, "_no_abort"}, n_abort - b_ab, 0);
    check({nm, "_data_vld"}, din_bad + vld_bad - b_bad, 0);
  endtask

  // Packed output vector compared against reset values:
  // {cfg_rdy, s_rdy, buf_frame_start, buf_din_vld, win_vld, frame_done, frame_aborted, cfg_err, busy}
  function automatic logic [8:0] outs();
    return {cfg_rdy, s_rdy, buf_frame_start, buf_din_vld, win_vld,
            frame_done, frame_aborted, cfg_err, busy};
  endfunction

  // Test sequence.
  initial begin
    int b_err, b_start, b_busy, b_done, b_ab, b_acc, b_win;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 9'b100000000);
    check("reset_state", dbg_state, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 stride 1, continuous stream.
    exp_q = '{16'h0202, 16'h0203, 16'h0302, 16'h0303};
    run_frame("f4x4", 4, 4, 1, 1'b0, 1'b0);

    // 5x5 stride 2.
    exp_q = '{16'h0202, 16'h0204, 16'h0402, 16'h0404};
    run_frame("f5x5s2", 5, 5, 2, 1'b0, 1'b0);

    // 4x4 with s_vld toggling.
    exp_q = '{16'h0202, 16'h0203, 16'h0302, 16'h0303};
    run_frame("f4x4_stall", 4, 4, 1, 1'b1, 1'b0);

    // Widest frame, minimum height.
    exp_q = {};
    for (int c = 2; c < 224; c++) exp_q.push_back(16'(16'h0200 + c));
    run_frame("f3x224", 3, 224, 1, 1'b0, 1'b0);

    // Rejected configurations.
    b_err = n_err; b_start = n_start; b_busy = n_busy;
    do_cfg(4, 2, 1, 1'b0);
    check("rej_w2_err", {cfg_err, busy}, 2'b10);
    do_cfg(225, 4, 1, 1'b0);
    check("rej_h225_err", {cfg_err, busy}, 2'b10);
    do_cfg(4, 4, 3, 1'b0);
    check("rej_s3_err", {cfg_err, busy}, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("rej_err_pulses", n_err - b_err, 3);
    check("rej_no_start", n_start - b_start, 0);
    check("rej_never_busy", n_busy - b_busy, 0);

    // Abort at row 1 col 2 of a 4x4 frame.
    b_done = n_done; b_ab = n_abort; b_acc = n_acc; b_win = n_win;
    do_cfg(4, 4, 1, 1'b0);
    stream(16, 1'b0, 6);
    check("abort_pulse_idle", {frame_aborted, cfg_rdy, busy}, 3'b110);
    repeat (12) @(posedge clk);
    #1;
    check("abort_count", n_abort - b_ab, 1);
    check("abort_no_done", n_done - b_done, 0);
    check("abort_accepted", n_acc - b_acc, 6);
    check("abort_no_win", n_win - b_win, 0);

    // Following frame, with abort asserted alongside the config in IDLE.
    exp_q = '{16'h0202, 16'h0203, 16'h0302, 16'h0303};
    run_frame("after_abort", 4, 4, 1, 1'b0, 1'b1);

    // Reset during DRAIN.
    b_done = n_done; b_ab = n_abort;
    do_cfg(4, 4, 1, 1'b0);
    stream(16, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    s_vld   = 1'b1;
    @(negedge clk);
    check("reset_mid_outs", outs(), 9'b100000000);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_hold_outs", outs(), 9'b100000000);
    @(posedge clk); #1;
    s_vld   = 1'b0;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("reset_no_done", n_done - b_done, 0);
    check("reset_no_abort", n_abort - b_ab, 0);
    check("reset_idle", {cfg_rdy, busy}, 2'b10);

    exp_q = '{16'h0202};
    run_frame("f3x3", 3, 3, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Controller that sequences one frame at a time into the row buffer / window datapath. It latches the per-frame configuration and issues the frame-start pulse. It gates the pixel stream with a valid/ready handshake, tracks row and column position, and flags which accepted pixels complete a window under the configured stride. It then waits out the buffer flush period before reporting frame completion.

Parameters:
FRAME_H_MAX, 224, maximum frame height in pixels
FRAME_W_MAX, 224, maximum frame width in pixels
DIN_WIDTH, 8, bits per channel
CH_NUM, 3, channels per pixel
WIN_SIZE, 3, window size (odd, >=3)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_vld  in  1  configuration request
cfg_rdy  out  1  high only in IDLE
cfg_h  in  clog2(FRAME_H_MAX)+1  frame height
cfg_w  in  clog2(FRAME_W_MAX)+1  frame width
cfg_stride  in  2  window stride (1 or 2)
cfg_err  out  1  one-cycle pulse when a configuration is rejected
abort  in  1  synchronous frame abort
s_vld  in  1  input pixel valid
s_rdy  out  1  input pixel ready
s_data  in  CH_NUM*DIN_WIDTH  input pixel
buf_frame_start  out  1  frame-start pulse to row buffer
buf_din_vld  out  1  pixel valid to row buffer
buf_din  out  CH_NUM*DIN_WIDTH  pixel to row buffer
win_vld  out  1  accepted pixel completes a strided window
frame_done  out  1  one-cycle pulse at end of frame
frame_aborted  out  1  one-cycle pulse on abort
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, counters 0, latched config 0. Outputs after reset:
  - cfg_rdy=1.
  - s_rdy, buf_frame_start, buf_din_vld, win_vld, frame_done, frame_aborted, cfg_err, busy all =0.
- State machine: IDLE -> START -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On cfg_vld, latch cfg_h, cfg_w, cfg_stride.
  - Reject the config if cfg_h<WIN_SIZE, cfg_w<WIN_SIZE, cfg_h>FRAME_H_MAX, cfg_w>FRAME_W_MAX, or cfg_stride not in {1,2}.
  - On reject: cfg_err pulses the next cycle and the state stays IDLE.
  - Otherwise: go to START.
- START (1 cycle):
  - buf_frame_start=1.
  - Row, column and stride-phase counters cleared.
  - Next state STREAM.
- STREAM:
  - s_rdy=1.
  - A pixel is accepted when s_vld & s_rdy.
  - buf_din_vld = accept and buf_din = s_data, combinational, zero latency.
  - buf_din is don't-care when buf_din_vld=0.
  - col increments per accepted pixel. At col==w-1, col wraps to 0 and row increments.
  - Accepting pixel (h-1, w-1) moves to DRAIN. s_rdy drops in the following cycle.
- Window flag:
  - win_vld=1 in the same cycle as an accepted pixel with row>=WIN_SIZE-1 and col>=WIN_SIZE-1.
  - Also requires (row-(WIN_SIZE-1)) and (col-(WIN_SIZE-1)) to both be divisible by stride.
  - Implement with phase counters reset at row/col = WIN_SIZE-1; no divider.
- DRAIN:
  - s_rdy=0.
  - Counts (WIN_SIZE-1)*w cycles, matching the row buffer's end-of-frame flush, then moves to DONE.
  - Drain counter width: clog2((WIN_SIZE-1)*FRAME_W_MAX)+1.
- DONE (1 cycle): frame_done=1, then IDLE; cfg_rdy returns the cycle after.
- abort:
  - In any non-IDLE state: next state IDLE, frame_aborted pulses 1 cycle, frame_done does not pulse.
  - A pixel presented in the abort cycle is not accepted: s_rdy is forced 0 when abort=1.
  - abort in IDLE is ignored.
  - abort and cfg_vld in the same IDLE cycle: the config is processed.
- Stalls: s_vld low in STREAM holds all counters. No timeout.
- Reset mid-frame: immediate return to IDLE with reset values. No frame_done or frame_aborted pulse.
- busy = (state != IDLE).

Test Plan:
- Config 4x4, stride 1, WIN_SIZE 3, continuous s_vld -> buf_frame_start single pulse one cycle before the first s_rdy. 16 pixels are accepted. win_vld exactly at (2,2), (2,3), (3,2), (3,3). DRAIN lasts 8 cycles, then one frame_done pulse.
- Config 5x5, stride 2 -> win_vld at (2,2), (2,4), (4,2), (4,4) only, 4 total. DRAIN lasts 10 cycles.
- Config 4x4 with s_vld toggling every other cycle -> same 16 accepted pixels and same win_vld positions. buf_din_vld matches the accept pattern exactly.
- Configs cfg_w=2, cfg_h=225, cfg_stride=3 -> cfg_err pulse each time, busy stays 0, no buf_frame_start.
- abort asserted at row 1 col 2 of a 4x4 frame -> that pixel is not accepted. frame_aborted pulses, no frame_done, cfg_rdy=1 the next cycle. A following 4x4 frame completes normally.
- reset_n low during DRAIN -> all outputs at reset values while low. After release, a new 3x3 frame gives exactly one win_vld, at (2,2).
